// File: rtl/mole_disp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mole_disp_pkg
// Description : Shared display types and constants for the mole game
//               display path (scan states, group split, letter patterns).
// Revision    : 1.0 - initial release
// ============================================================================
package mole_disp_pkg;

  // Scan phase within one digit slot
  typedef enum logic [0:0] {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_e;

  // Digit group split on the 8-digit display
  localparam int LEFT_BASE        = 4;
  localparam int RIGHT_BASE       = 0;
  localparam int DIGITS_PER_GROUP = 4;

  // Letter patterns, active high {dp,g,f,e,d,c,b,a}
  localparam logic [7:0] _r = 8'h50;
  localparam logic [7:0] _d = 8'h5E;
  localparam logic [7:0] _m = 8'h37;
  localparam logic [7:0] _l = 8'h38;
  localparam logic [7:0] _u = 8'h1C;

endpackage
`default_nettype wire

// File: rtl/scan_timer.sv
`default_nettype none
// ============================================================================
// Module      : scan_timer
// Description : Slot counter, slot index and frame_done pulse for the digit
//               scanner. Exposes both current and next counter values so the
//               parent can register outputs aligned to the counter.
// Revision    : 1.0 - initial release
// ============================================================================
module scan_timer #(
  parameter int SLOT_CYCLES = 100000,
  parameter int CNT_W       = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [CNT_W-1:0] o_sc,
  output logic [CNT_W-1:0] o_sc_nxt,
  output logic [1:0]       o_idx,
  output logic [1:0]       o_idx_nxt,
  output logic             o_frame_done
);

  localparam logic [CNT_W-1:0] c_last = CNT_W'(SLOT_CYCLES - 1);

  logic [CNT_W-1:0] r_sc;
  logic [1:0]       r_idx;
  logic             r_frame_done;
  logic             w_wrap;
  logic [CNT_W-1:0] w_sc_nxt;
  logic [1:0]       w_idx_nxt;

  // Next counter values: wrap the slot counter, advance the index on wrap
  always_comb begin
    w_wrap    = (r_sc == c_last);
    w_sc_nxt  = w_wrap ? '0 : r_sc + CNT_W'(1);
    w_idx_nxt = w_wrap ? r_idx + 2'd1 : r_idx;
  end

  // Counter registers; frame_done is registered so it is high while the
  // counter sits on the last cycle of slot 3
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sc         <= '0;
      r_idx        <= 2'd0;
      r_frame_done <= 1'b0;
    end else begin
      r_sc         <= w_sc_nxt;
      r_idx        <= w_idx_nxt;
      r_frame_done <= (w_sc_nxt == c_last) && (w_idx_nxt == 2'd3);
    end
  end

  assign o_sc         = r_sc;
  assign o_sc_nxt     = w_sc_nxt;
  assign o_idx        = r_idx;
  assign o_idx_nxt    = w_idx_nxt;
  assign o_frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: rtl/seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_driver
// Description : Time-multiplexed driver for the 8-digit display. Snapshots the
//               frame request at each frame start, then scans one digit per
//               group per slot with a blanking gap at the start of each slot.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_driver
  import mole_disp_pkg::*;
#(
  parameter int SLOT_CYCLES  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] dig_display,
  input  logic [7:0] seg_code_1,
  input  logic [7:0] seg_code_2,
  output logic [7:0] an,
  output logic [7:0] seg_out_1,
  output logic [7:0] seg_out_2,
  output logic       frame_done
);

  localparam int               c_cnt_w     = $clog2(SLOT_CYCLES);
  localparam logic [c_cnt_w-1:0] c_blank_end = c_cnt_w'(BLANK_CYCLES);
  localparam logic [2:0]       c_left_base  = 3'(LEFT_BASE);
  localparam logic [2:0]       c_right_base = 3'(RIGHT_BASE);

  logic [c_cnt_w-1:0] w_sc;
  logic [c_cnt_w-1:0] w_sc_nxt;
  logic [1:0]         w_idx;
  logic [1:0]         w_idx_nxt;

  scan_state_e r_state;
  scan_state_e w_state_nxt;

  logic [7:0] r_mask;
  logic [7:0] r_seg1;
  logic [7:0] r_seg2;
  logic [7:0] w_mask_nxt;
  logic [7:0] w_seg1_nxt;
  logic [7:0] w_seg2_nxt;
  logic       w_load;

  logic [2:0] w_lidx;
  logic [2:0] w_ridx;
  logic [7:0] w_an_nxt;
  logic [7:0] w_seg1_out_nxt;
  logic [7:0] w_seg2_out_nxt;

  logic [7:0] r_an;
  logic [7:0] r_seg_out_1;
  logic [7:0] r_seg_out_2;

  scan_timer #(
    .SLOT_CYCLES (SLOT_CYCLES),
    .CNT_W       (c_cnt_w)
  ) u_scan_timer (
    .clk          (clk),
    .rst_n        (rst_n),
    .o_sc         (w_sc),
    .o_sc_nxt     (w_sc_nxt),
    .o_idx        (w_idx),
    .o_idx_nxt    (w_idx_nxt),
    .o_frame_done (frame_done)
  );

  // Snapshot source: load on the edge closing counter 0 of slot 0. The output
  // path looks at the post-edge snapshot so a new frame shows at once.
  always_comb begin
    w_load     = (w_sc == '0) && (w_idx == 2'd0);
    w_mask_nxt = w_load ? dig_display : r_mask;
    w_seg1_nxt = w_load ? seg_code_1  : r_seg1;
    w_seg2_nxt = w_load ? seg_code_2  : r_seg2;
  end

  // Shadow registers holding the frame request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mask <= 8'h00;
      r_seg1 <= 8'h00;
      r_seg2 <= 8'h00;
    end else begin
      r_mask <= w_mask_nxt;
      r_seg1 <= w_seg1_nxt;
      r_seg2 <= w_seg2_nxt;
    end
  end

  // Scan FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= BLANK;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state follows the counter value that will be present after the edge
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      BLANK:   if (w_sc_nxt == c_blank_end) w_state_nxt = DRIVE;
      DRIVE:   if (w_sc_nxt == '0)          w_state_nxt = BLANK;
      default: w_state_nxt = BLANK;
    endcase
  end

  // Output values for the upcoming counter value: one digit per group
  always_comb begin
    w_lidx         = c_left_base  + {1'b0, w_idx_nxt};
    w_ridx         = c_right_base + {1'b0, w_idx_nxt};
    w_an_nxt       = 8'h00;
    w_seg1_out_nxt = 8'h00;
    w_seg2_out_nxt = 8'h00;
    if (w_state_nxt == DRIVE) begin
      w_an_nxt[w_lidx] = w_mask_nxt[w_lidx];
      w_an_nxt[w_ridx] = w_mask_nxt[w_ridx];
      if (w_mask_nxt[w_lidx]) w_seg1_out_nxt = w_seg1_nxt;
      if (w_mask_nxt[w_ridx]) w_seg2_out_nxt = w_seg2_nxt;
    end
  end

  // Registered display outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_an        <= 8'h00;
      r_seg_out_1 <= 8'h00;
      r_seg_out_2 <= 8'h00;
    end else begin
      r_an        <= w_an_nxt;
      r_seg_out_1 <= w_seg1_out_nxt;
      r_seg_out_2 <= w_seg2_out_nxt;
    end
  end

  assign an        = r_an;
  assign seg_out_1 = r_seg_out_1;
  assign seg_out_2 = r_seg_out_2;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_scan_driver
// Description : Self-checking bench for seg_scan_driver with a cycle model
//               feeding an expected-output queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scan_driver;

  localparam int SLOT  = 8;
  localparam int BLANK = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] dig_display;
  logic [7:0] seg_code_1;
  logic [7:0] seg_code_2;
  logic [7:0] an;
  logic [7:0] seg_out_1;
  logic [7:0] seg_out_2;
  logic       frame_done;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [7:0] an;
    logic [7:0] s1;
    logic [7:0] s2;
    logic       fd;
    int         sc;
    int         idx;
  } exp_t;

  exp_t q_exp[$];

  int         m_sc   = 0;
  int         m_idx  = 0;
  logic [7:0] m_mask = 8'h00;
  logic [7:0] m_s1   = 8'h00;
  logic [7:0] m_s2   = 8'h00;

  seg_scan_driver #(
    .SLOT_CYCLES  (SLOT),
    .BLANK_CYCLES (BLANK)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .dig_display (dig_display),
    .seg_code_1  (seg_code_1),
    .seg_code_2  (seg_code_2),
    .an          (an),
    .seg_out_1   (seg_out_1),
    .seg_out_2   (seg_out_2),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  function automatic exp_t make_exp();
    exp_t e;
    e.sc  = m_sc;
    e.idx = m_idx;
    e.an  = 8'h00;
    e.s1  = 8'h00;
    e.s2  = 8'h00;
    if (m_sc >= BLANK) begin
      if (m_mask[m_idx + 4]) begin
        e.an[m_idx + 4] = 1'b1;
        e.s1 = m_s1;
      end
      if (m_mask[m_idx]) begin
        e.an[m_idx] = 1'b1;
        e.s2 = m_s2;
      end
    end
    e.fd = (m_idx == 3) && (m_sc == SLOT - 1);
    return e;
  endfunction

  // Reference model: advances on each edge and queues what the outputs must
  // show for the counter value reached by that edge
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_sc   = 0;
      m_idx  = 0;
      m_mask = 8'h00;
      m_s1   = 8'h00;
      m_s2   = 8'h00;
      q_exp.delete();
    end else begin
      if (m_sc == 0 && m_idx == 0) begin
        m_mask = dig_display;
        m_s1   = seg_code_1;
        m_s2   = seg_code_2;
      end
      if (m_sc == SLOT - 1) begin
        m_sc  = 0;
        m_idx = (m_idx + 1) % 4;
      end else begin
        m_sc = m_sc + 1;
      end
      q_exp.push_back(make_exp());
    end
  end

  // Wait for the next sample point and pop the matching expectation; an
  // empty queue yields X expectations that can never match
  task automatic next_cycle(output exp_t e);
    @(negedge clk);
    if (q_exp.size() > 0) begin
      e = q_exp.pop_front();
    end else begin
      e.an = 8'hxx; e.s1 = 8'hxx; e.s2 = 8'hxx; e.fd = 1'bx;
      e.sc = -1; e.idx = -1;
    end
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    dig_display = 8'hFF;
    seg_code_1  = 8'h06;
    seg_code_2  = 8'h5B;
    repeat (3) @(negedge clk);
    n_total++;
    if (an !== 8'h00) $display("FAIL reset_an got=%h exp=%h", an, 8'h00); else n_pass++;
    n_total++;
    if (seg_out_1 !== 8'h00) $display("FAIL reset_seg1 got=%h exp=%h", seg_out_1, 8'h00); else n_pass++;
    n_total++;
    if (seg_out_2 !== 8'h00) $display("FAIL reset_seg2 got=%h exp=%h", seg_out_2, 8'h00); else n_pass++;
    n_total++;
    if (frame_done !== 1'b0) $display("FAIL reset_fd got=%b exp=%b", frame_done, 1'b0); else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_full_mask();
    exp_t e;
    int   fd_cnt = 0;
    for (int i = 0; i < 32; i++) begin
      next_cycle(e);
      n_total++;
      if ({an, seg_out_1, seg_out_2, frame_done} !== {e.an, e.s1, e.s2, e.fd}) begin
        $display("FAIL full_mask sc=%0d idx=%0d got an=%h s1=%h s2=%h fd=%b exp an=%h s1=%h s2=%h fd=%b",
                 e.sc, e.idx, an, seg_out_1, seg_out_2, frame_done, e.an, e.s1, e.s2, e.fd);
      end else n_pass++;
      if (frame_done === 1'b1) fd_cnt++;
      if (e.sc == 4) begin
        n_total++;
        if ({an, seg_out_1, seg_out_2} !== {8'h11 << e.idx, 8'h06, 8'h5B})
          $display("FAIL full_mask_slot%0d got an=%h s1=%h s2=%h exp an=%h s1=06 s2=5b",
                   e.idx, an, seg_out_1, seg_out_2, 8'h11 << e.idx);
        else n_pass++;
      end
    end
    n_total++;
    if (fd_cnt !== 1) $display("FAIL full_mask_fd_count got=%0d exp=1", fd_cnt); else n_pass++;
  endtask

  task automatic test_right_only();
    exp_t e;
    int   fd_cnt = 0;
    int   s1_hits = 0;
    int   guard = 0;
    dig_display = 8'h0F;
    // run to the latch cycle of the next frame
    do begin
      next_cycle(e);
      guard++;
      n_total++;
      if ({an, seg_out_1, seg_out_2, frame_done} !== {e.an, e.s1, e.s2, e.fd})
        $display("FAIL right_sync got an=%h s1=%h s2=%h fd=%b exp an=%h s1=%h s2=%h fd=%b",
                 an, seg_out_1, seg_out_2, frame_done, e.an, e.s1, e.s2, e.fd);
      else n_pass++;
    end while (!(e.sc == 0 && e.idx == 0) && guard < 80);
    n_total++;
    if (guard >= 80) $display("FAIL right_sync_timeout got=%0d exp<80", guard); else n_pass++;
    for (int i = 0; i < 64; i++) begin
      next_cycle(e);
      n_total++;
      if ({an, seg_out_1, seg_out_2, frame_done} !== {e.an, e.s1, e.s2, e.fd})
        $display("FAIL right_only sc=%0d idx=%0d got an=%h s1=%h s2=%h fd=%b exp an=%h s1=%h s2=%h fd=%b",
                 e.sc, e.idx, an, seg_out_1, seg_out_2, frame_done, e.an, e.s1, e.s2, e.fd);
      else n_pass++;
      if (frame_done === 1'b1) fd_cnt++;
      if (seg_out_1 !== 8'h00) s1_hits++;
    end
    n_total++;
    if (fd_cnt !== 2) $display("FAIL right_only_fd_count got=%0d exp=2", fd_cnt); else n_pass++;
    n_total++;
    if (s1_hits !== 0) $display("FAIL right_only_seg1_lit got=%0d exp=0", s1_hits); else n_pass++;
  endtask

  task automatic test_midframe_change();
    exp_t e;
    int   guard = 0;
    do begin
      next_cycle(e);
      guard++;
    end while (!(e.sc == 0 && e.idx == 0) && guard < 80);
    // change on the very latch edge is captured
    dig_display = 8'hFF;
    seg_code_2  = 8'h5B;
    n_total++;
    if (guard >= 80) $display("FAIL mid_sync_timeout got=%0d exp<80", guard); else n_pass++;
    guard = 0;
    do begin
      next_cycle(e);
      guard++;
      n_total++;
      if ({an, seg_out_1, seg_out_2, frame_done} !== {e.an, e.s1, e.s2, e.fd})
        $display("FAIL mid_pre got an=%h s1=%h s2=%h fd=%b exp an=%h s1=%h s2=%h fd=%b",
                 an, seg_out_1, seg_out_2, frame_done, e.an, e.s1, e.s2, e.fd);
      else n_pass++;
    end while (!(e.sc == 3 && e.idx == 1) && guard < 80);
    seg_code_2 = 8'h3F;
    for (int i = 0; i < 44; i++) begin
      next_cycle(e);
      n_total++;
      if ({an, seg_out_1, seg_out_2, frame_done} !== {e.an, e.s1, e.s2, e.fd})
        $display("FAIL mid_change sc=%0d idx=%0d got an=%h s1=%h s2=%h fd=%b exp an=%h s1=%h s2=%h fd=%b",
                 e.sc, e.idx, an, seg_out_1, seg_out_2, frame_done, e.an, e.s1, e.s2, e.fd);
      else n_pass++;
      if (i < 20 && e.sc == 5) begin
        n_total++;
        if (seg_out_2 !== 8'h5B) $display("FAIL mid_old_pattern got=%h exp=%h", seg_out_2, 8'h5B);
        else n_pass++;
      end
      if (i >= 20 && e.idx == 0 && e.sc == 5) begin
        n_total++;
        if (seg_out_2 !== 8'h3F) $display("FAIL mid_new_pattern got=%h exp=%h", seg_out_2, 8'h3F);
        else n_pass++;
      end
    end
  endtask

  task automatic test_zero_mask();
    exp_t e;
    int   guard = 0;
    int   an_hits = 0;
    int   fd_cnt = 0;
    do begin
      next_cycle(e);
      guard++;
    end while (!(e.sc == 0 && e.idx == 0) && guard < 80);
    dig_display = 8'h00;
    n_total++;
    if (guard >= 80) $display("FAIL zero_sync_timeout got=%0d exp<80", guard); else n_pass++;
    for (int i = 0; i < 32; i++) begin
      next_cycle(e);
      n_total++;
      if ({an, seg_out_1, seg_out_2, frame_done} !== {e.an, e.s1, e.s2, e.fd})
        $display("FAIL zero_mask sc=%0d idx=%0d got an=%h s1=%h s2=%h fd=%b exp an=%h s1=%h s2=%h fd=%b",
                 e.sc, e.idx, an, seg_out_1, seg_out_2, frame_done, e.an, e.s1, e.s2, e.fd);
      else n_pass++;
      if (an !== 8'h00) an_hits++;
      if (frame_done === 1'b1) fd_cnt++;
    end
    n_total++;
    if (an_hits !== 0) $display("FAIL zero_mask_an_lit got=%0d exp=0", an_hits); else n_pass++;
    n_total++;
    if (fd_cnt !== 1) $display("FAIL zero_mask_fd_count got=%0d exp=1", fd_cnt); else n_pass++;
  endtask

  task automatic test_reset_mid_slot();
    exp_t e;
    int   guard = 0;
    dig_display = 8'hFF;
    do begin
      next_cycle(e);
      guard++;
    end while (!(e.sc == 5 && e.idx == 2) && guard < 80);
    n_total++;
    if (guard >= 80) $display("FAIL rst_sync_timeout got=%0d exp<80", guard); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if ({an, seg_out_1, seg_out_2} !== 24'h0)
      $display("FAIL rst_async got an=%h s1=%h s2=%h exp all 00", an, seg_out_1, seg_out_2);
    else n_pass++;
    @(negedge clk);
    dig_display = 8'hF0;
    seg_code_1  = 8'h5E;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 34; i++) begin
      next_cycle(e);
      n_total++;
      if ({an, seg_out_1, seg_out_2, frame_done} !== {e.an, e.s1, e.s2, e.fd})
        $display("FAIL rst_restart sc=%0d idx=%0d got an=%h s1=%h s2=%h fd=%b exp an=%h s1=%h s2=%h fd=%b",
                 e.sc, e.idx, an, seg_out_1, seg_out_2, frame_done, e.an, e.s1, e.s2, e.fd);
      else n_pass++;
      if (i == 1) begin
        n_total++;
        if ({an, seg_out_1} !== {8'h10, 8'h5E})
          $display("FAIL rst_first_drive got an=%h s1=%h exp an=10 s1=5e", an, seg_out_1);
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_mask();
    test_right_only();
    test_midframe_change();
    test_zero_mask();
    test_reset_mid_slot();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
